// File: rtl/serial_parity_rx.sv
// serial_parity_rx: serial frame receiver with parity check and valid/ready output.
// Define SERIAL_RX_PARITY_EN to receive and check a parity bit after the data bits.
module serial_parity_rx #(
  parameter int N_DATA     = 8,
  parameter int BIT_CYCLES = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              rxd,
  input  logic              out_ready,
  output logic [N_DATA-1:0] data,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(N_DATA + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] LAST = BW'(N_DATA - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic s1, s2, s2_d, tick, fall, done, perr, hs;
  logic [1:0] fill;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bits, bits_nx;
  logic [N_DATA-1:0] sh, sh_nx, sh_in;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic ODD = PARITY_ODD != 0;
  localparam state_t AFTER_DATA = PARITY;
  logic pbit;
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) pbit <= 1'b0;
    else if (state == PARITY && tick) pbit <= s2;
  assign perr = (^sh ^ pbit) ~^ ~ODD;
`else
  localparam state_t AFTER_DATA = STOP;
  logic unused_odd;
  assign unused_odd = PARITY_ODD[0];
  assign perr = 1'b0;
`endif
  assign tick = cnt == '0;
  assign fall = s2_d & ~s2;
  assign busy = state != IDLE;
  assign hs   = out_valid & out_ready;
  always_comb begin
    sh_in = sh >> 1;
    sh_in[N_DATA-1] = s2;
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = tick ? '0 : cnt - 1'b1;
    bits_nx  = bits;
    sh_nx    = sh;
    done     = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_nx = START;
        cnt_nx   = HALF;
      end
      START: if (tick) begin
        state_nx = s2 ? IDLE : DATA;
        cnt_nx   = s2 ? '0 : FULL;
        bits_nx  = '0;
      end
      DATA: if (tick) begin
        sh_nx    = sh_in;
        bits_nx  = bits + 1'b1;
        cnt_nx   = FULL;
        state_nx = bits == LAST ? AFTER_DATA : DATA;
      end
      PARITY: if (tick) begin
        state_nx = STOP;
        cnt_nx   = FULL;
      end
      STOP: if (tick) begin
        state_nx = IDLE;
        done     = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  // s2_d only captures a real high once the synchroniser has refilled from the line,
  // so a line already low when reset releases is not mistaken for a start edge
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      sh    <= '0;
      s1    <= 1'b1;
      s2    <= 1'b1;
      s2_d  <= 1'b0;
      fill  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bits  <= bits_nx;
      sh    <= sh_nx;
      s1    <= rxd;
      s2    <= s1;
      s2_d  <= s2 & fill[1];
      fill  <= {fill[0], 1'b1};
    end
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) begin
      data       <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done && (!out_valid || out_ready)) begin
        data       <= sh;
        parity_err <= perr;
        frame_err  <= ~s2;
        out_valid  <= 1'b1;
      end else if (hs) out_valid <= 1'b0;
      overrun <= hs ? 1'b0 : (overrun | (done & out_valid));
    end
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: scoreboard bench for serial_parity_rx (even and odd parity instances).
module tb_serial_parity_rx;
  localparam int N  = 8;
  localparam int BC = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT = BC / 2 + 2 + (N + 1 + int'(PAR)) * BC;
  typedef struct {logic [7:0] d; logic pe, ope, fe, ov;} exp_t;
  logic clock = 1'b0, reset_ = 1'b1, rxd = 1'b1, out_ready = 1'b0;
  logic [N-1:0] data, o_data;
  logic out_valid, parity_err, frame_err, overrun, busy;
  logic o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;
  exp_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0, last_rise = -1, last_t0 = 0;
  logic ov_prev = 1'b0;
  serial_parity_rx #(.N_DATA(N), .BIT_CYCLES(BC), .PARITY_ODD(0)) dut (
    .clock(clock), .reset_(reset_), .rxd(rxd), .out_ready(out_ready), .data(data),
    .out_valid(out_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy));
  serial_parity_rx #(.N_DATA(N), .BIT_CYCLES(BC), .PARITY_ODD(1)) dut_o (
    .clock(clock), .reset_(reset_), .rxd(rxd), .out_ready(out_ready), .data(o_data),
    .out_valid(o_valid), .parity_err(o_parity_err), .frame_err(o_frame_err),
    .overrun(o_overrun), .busy(o_busy));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (out_valid && !ov_prev) last_rise = cyc;
    ov_prev = out_valid;
  end
  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit push, input logic ov, input int gap);
    exp_t e;
    e.d   = d;
    e.pe  = PAR && ($countones({d, par}) % 2 == 1);
    e.ope = PAR && ($countones({d, par}) % 2 == 0);
    e.fe  = ~stp;
    e.ov  = ov;
    if (push) exp_q.push_back(e);
    if (gap > 0) drive(1'b1, gap);
    last_t0 = cyc + 1;
    drive(1'b0, BC);
    for (int i = 0; i < N; i++) drive(d[i], BC);
    if (PAR) drive(par, BC);
    drive(stp, BC);
  endtask
  task automatic check_word(input string name);
    exp_t e;
    int n = 0;
    @(negedge clock);
    while (!out_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (!out_valid || exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: out_valid=%b queued=%0d, required a presented word", name, out_valid, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    tests += 6;
    if (data !== e.d) begin fails++; $display("FAIL %s data: got %h want %h", name, data, e.d); end
    if (parity_err !== e.pe) begin fails++; $display("FAIL %s parity_err: got %b want %b", name, parity_err, e.pe); end
    if (frame_err !== e.fe) begin fails++; $display("FAIL %s frame_err: got %b want %b", name, frame_err, e.fe); end
    if (overrun !== e.ov) begin fails++; $display("FAIL %s overrun: got %b want %b", name, overrun, e.ov); end
    if (o_data !== e.d) begin fails++; $display("FAIL %s odd data: got %h want %h", name, o_data, e.d); end
    if (o_parity_err !== e.ope) begin fails++; $display("FAIL %s odd parity_err: got %b want %b", name, o_parity_err, e.ope); end
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    @(negedge clock);
    tests++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL %s handshake: out_valid=%b overrun=%b want 0 0", name, out_valid, overrun);
    end
  endtask
  task automatic test_reset;
    #1 reset_ = 1'b0;
    #2;
    tests++;
    if ({data, out_valid, parity_err, frame_err, overrun, busy} !== '0 ||
        {o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy} !== '0) begin
      fails++;
      $display("FAIL reset: data=%h v=%b pe=%b fe=%b ov=%b busy=%b, all required 0",
               data, out_valid, parity_err, frame_err, overrun, busy);
    end
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    repeat (5) @(negedge clock);
  endtask
  task automatic test_parity;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    tests++;
    if (last_rise - last_t0 !== LAT) begin
      fails++;
      $display("FAIL valid_timing: rose %0d cycles after start, want %0d", last_rise - last_t0, LAT);
    end
    check_word("a5_par0");
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    check_word("a5_par1");
  endtask
  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    check_word("3c_stop0");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    check_word("5a_after_ferr");
  endtask
  task automatic test_back_to_back;
    drive(1'b1, 4);
    drive(1'b0, 4);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b want 1", busy); end
    drive(1'b1, 30);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL false_start: busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 4);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_word("overrun_3c");
  endtask
  task automatic test_reset_mid;
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, BC);
    drive(1'b1, BC);
    drive(1'b0, 2 * BC);
    drive(1'b0, BC / 2);
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: out_valid=%b busy=%b want 1 1", out_valid, busy);
    end
    #2 reset_ = 1'b0;
    #1;
    tests++;
    if ({data, out_valid, parity_err, frame_err, overrun, busy, o_valid, o_busy} !== '0) begin
      fails++;
      $display("FAIL mid_reset: data=%h v=%b pe=%b fe=%b ov=%b busy=%b, all required 0",
               data, out_valid, parity_err, frame_err, overrun, busy);
    end
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    repeat (40) @(negedge clock);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL low_after_reset: busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 8);
    tests++;
    if (last_rise - last_t0 !== LAT) begin
      fails++;
      $display("FAIL valid_timing_81: rose %0d cycles after start, want %0d", last_rise - last_t0, LAT);
    end
    check_word("81_after_reset");
  endtask
  initial begin
    test_reset;
    test_parity;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d words left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
